// File: rtl/ratio_sin_engine.sv
// ratio_sin_engine: y = floor((a << FRAC) / (a+b+c)) * sin_data using an iterative divider and multiplier
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, a, b, c        : operation request and operands, captured on the accepting edge
//   ser_in, ser_en        : serial angle input (MSB first) and its shift enable
//   sin_addr, sin_data    : angle snapshot to the external sine ROM and its combinational result
//   busy, done, div_zero  : in progress, one-cycle result pulse, zero divisor flag for y
//   y                     : product, held until the next done
module ratio_sin_engine #(
  parameter int W     = 12,
  parameter int FRAC  = 14,
  parameter int SER_W = 10,
  parameter int S_W   = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [W-1:0]            a,
  input  logic [W-1:0]            b,
  input  logic [W-1:0]            c,
  input  logic                    ser_in,
  input  logic                    ser_en,
  output logic [SER_W-1:0]        sin_addr,
  input  logic [S_W-1:0]          sin_data,
  output logic                    busy,
  output logic                    done,
  output logic                    div_zero,
  output logic [W+FRAC+S_W-1:0]   y
);
  localparam int Q_W = W + FRAC;
  localparam int D_W = W + 2;
  localparam int P_W = Q_W + S_W;
  localparam int C_W = $clog2(Q_W > S_W ? Q_W : S_W) + 1;
  typedef enum logic [1:0] {IDLE, DIV, MUL, DONE} state_t;
  state_t           state_q, state_d;
  logic [SER_W-1:0] sh_q, addr_q, addr_d;
  logic [Q_W-1:0]   dvd_q, dvd_d, quo_q, quo_d, quo_nx;
  logic [D_W-1:0]   dvs_q, dvs_d, sum;
  logic [D_W:0]     rem_q, rem_d;
  logic [D_W+1:0]   rem_sh;
  logic [C_W-1:0]   cnt_q, cnt_d;
  logic [S_W-1:0]   mul_q, mul_d;
  logic [P_W-1:0]   acc_q, acc_d, acc_nx, y_q, y_d;
  logic             dz_q, dz_d, div_zero_q, div_zero_d, accept, ge;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sh_q <= '0;
    else if (ser_en) sh_q <= {sh_q[SER_W-2:0], ser_in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      mul_q      <= '0;
      acc_q      <= '0;
      y_q        <= '0;
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      cnt_q      <= cnt_d;
      mul_q      <= mul_d;
      acc_q      <= acc_d;
      y_q        <= y_d;
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
    end
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    cnt_d      = cnt_q;
    mul_d      = mul_q;
    acc_d      = acc_q;
    y_d        = y_q;
    dz_d       = dz_q;
    div_zero_d = div_zero_q;
    accept     = start && (state_q == IDLE || state_q == DONE);
    sum        = D_W'(a) + D_W'(b) + D_W'(c);
    rem_sh     = {rem_q, dvd_q[Q_W-1]};
    ge         = rem_sh >= (D_W+2)'(dvs_q);
    quo_nx     = {quo_q[Q_W-2:0], ge};
    acc_nx     = acc_q + (mul_q[0] ? (P_W'(quo_q) << cnt_q) : '0);
    case (state_q)
      DIV: begin
        rem_d = (D_W+1)'(ge ? rem_sh - (D_W+2)'(dvs_q) : rem_sh);
        dvd_d = dvd_q << 1;
        quo_d = quo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_W'(Q_W-1)) begin
          // a zero divisor saturates the quotient regardless of the iteration result
          quo_d   = dz_q ? '1 : quo_nx;
          mul_d   = sin_data;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d = acc_nx;
        mul_d = mul_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_W'(S_W-1)) begin
          y_d        = acc_nx;
          div_zero_d = dz_q;
          state_d    = DONE;
        end
      end
      default: begin
        state_d = accept ? DIV : IDLE;
        if (accept) begin
          dvd_d  = Q_W'(a) << FRAC;
          dvs_d  = sum;
          dz_d   = sum == '0;
          addr_d = sh_q;
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = '0;
        end
      end
    endcase
  end
  assign sin_addr = addr_q;
  assign busy     = state_q == DIV || state_q == MUL;
  assign done     = state_q == DONE;
  assign div_zero = div_zero_q;
  assign y        = y_q;
endmodule
